vpu_op_sequencer: RTL and testbench

VPU_OP_SEQUENCER -- requirements
Module: vpu_op_sequencer

---
 rtl/vpu_op_sequencer.sv | 173 +++++++++++++++++
 tb/tb_vpu_op_sequencer.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_op_sequencer.sv
// Vector-op sequencer: reads up to three source vectors per element from SRAM,
// issues them to the datapath, and writes each result back, for req_len vectors.
module vpu_op_sequencer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [4:0]          req_opcode,
    input  logic [1:0]          req_nsrc,
    input  logic [3*ADDR_W-1:0] req_src_addr,
    input  logic [ADDR_W-1:0]   req_dst_addr,
    input  logic [LEN_W-1:0]    req_len,
    output logic                sram_rd_req,
    output logic [ADDR_W-1:0]   sram_rd_addr,
    input  logic                sram_rd_gnt,
    input  logic                sram_rd_rvalid,
    input  logic [511:0]        sram_rd_rdata,
    output logic                dp_valid,
    input  logic                dp_ready,
    output logic [4:0]          dp_opcode,
    output logic [3*512-1:0]    dp_src,
    input  logic                dp_res_valid,
    input  logic [511:0]        dp_res_data,
    output logic                sram_wr_req,
    input  logic                sram_wr_gnt,
    output logic [ADDR_W-1:0]   sram_wr_addr,
    output logic [511:0]        sram_wr_data,
    output logic                busy,
    output logic                done
);

    localparam int unsigned DATA_W = 512;
    localparam int unsigned NSLOT  = 3;

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_WAIT, EXEC, WAIT_RES, WR, DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [4:0]          opcode_q;
    logic [1:0]          nsrc_q;
    logic [1:0]          op_idx;
    logic [ADDR_W-1:0]   src_addr_q [NSLOT];
    logic [ADDR_W-1:0]   dst_addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    vec_idx;
    logic [DATA_W-1:0]   src_q [NSLOT];
    logic [DATA_W-1:0]   res_q;
    logic [ADDR_W-1:0]   cur_src_addr_c;
    logic                accept_c;
    logic                last_op_c;
    logic                last_vec_c;

    assign accept_c   = req_valid && (state == IDLE);
    assign last_op_c  = (op_idx + 2'd1) >= nsrc_q;
    assign last_vec_c = (vec_idx + LEN_W'(1)) == len_q;

    always_comb begin
        case (op_idx)
            2'd0:    cur_src_addr_c = src_addr_q[0];
            2'd1:    cur_src_addr_c = src_addr_q[1];
            default: cur_src_addr_c = src_addr_q[2];
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req_valid) state_nxt = (req_len == '0) ? DONE : RD_ISSUE;
            RD_ISSUE: if (sram_rd_gnt) state_nxt = RD_WAIT;
            RD_WAIT:  if (sram_rd_rvalid) state_nxt = last_op_c ? EXEC : RD_ISSUE;
            EXEC:     if (dp_ready) state_nxt = WAIT_RES;
            WAIT_RES: if (dp_res_valid) state_nxt = WR;
            WR:       if (sram_wr_gnt) state_nxt = last_vec_c ? DONE : RD_ISSUE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Command capture, operand/result storage and element counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q   <= '0;
            nsrc_q     <= '0;
            dst_addr_q <= '0;
            len_q      <= '0;
            vec_idx    <= '0;
            op_idx     <= '0;
            res_q      <= '0;
            for (int unsigned i = 0; i < NSLOT; i++) begin
                src_addr_q[i] <= '0;
                src_q[i]      <= '0;
            end
        end else begin
            if (accept_c) begin
                opcode_q   <= req_opcode;
                nsrc_q     <= (req_nsrc == 2'd0) ? 2'd1 : req_nsrc;
                dst_addr_q <= req_dst_addr;
                len_q      <= req_len;
                vec_idx    <= '0;
                op_idx     <= '0;
                res_q      <= '0;
                for (int unsigned i = 0; i < NSLOT; i++) begin
                    src_addr_q[i] <= req_src_addr[i*ADDR_W +: ADDR_W];
                    src_q[i]      <= '0;
                end
            end
            if (state == RD_WAIT && sram_rd_rvalid) begin
                case (op_idx)
                    2'd0:    src_q[0] <= sram_rd_rdata;
                    2'd1:    src_q[1] <= sram_rd_rdata;
                    default: src_q[2] <= sram_rd_rdata;
                endcase
                if (!last_op_c) op_idx <= op_idx + 2'd1;
            end
            if (state == WAIT_RES && dp_res_valid) res_q <= dp_res_data;
            if (state == WR && sram_wr_gnt) begin
                vec_idx <= vec_idx + LEN_W'(1);
                op_idx  <= '0;
            end
        end
    end

    // Outputs decoded from state and captured registers
    always_comb begin
        req_ready    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        sram_rd_req  = 1'b0;
        sram_rd_addr = '0;
        dp_valid     = 1'b0;
        dp_opcode    = '0;
        dp_src       = '0;
        sram_wr_req  = 1'b0;
        sram_wr_addr = '0;
        sram_wr_data = '0;
        req_ready    = (state == IDLE);
        busy         = (state != IDLE);
        done         = (state == DONE);
        case (state)
            RD_ISSUE: begin
                sram_rd_req  = 1'b1;
                sram_rd_addr = cur_src_addr_c + ADDR_W'(vec_idx);
            end
            EXEC: begin
                dp_valid  = 1'b1;
                dp_opcode = opcode_q;
                // Slots beyond the operand count stay zero even if stale data is held
                for (int unsigned i = 0; i < NSLOT; i++) begin
                    if (2'(i) < nsrc_q) dp_src[i*DATA_W +: DATA_W] = src_q[i];
                end
            end
            WR: begin
                sram_wr_req  = 1'b1;
                sram_wr_addr = dst_addr_q + ADDR_W'(vec_idx);
                sram_wr_data = res_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vpu_op_sequencer.sv
// Directed bench for vpu_op_sequencer with SRAM and datapath responders.
module tb_vpu_op_sequencer;

    localparam int unsigned AW = 16;
    localparam int unsigned LW = 8;
    localparam int unsigned DW = 512;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [4:0]      req_opcode = '0;
    logic [1:0]      req_nsrc = '0;
    logic [3*AW-1:0] req_src_addr = '0;
    logic [AW-1:0]   req_dst_addr = '0;
    logic [LW-1:0]   req_len = '0;
    logic            sram_rd_req;
    logic [AW-1:0]   sram_rd_addr;
    logic            sram_rd_gnt = 1'b0;
    logic            sram_rd_rvalid = 1'b0;
    logic [DW-1:0]   sram_rd_rdata = '0;
    logic            dp_valid;
    logic            dp_ready = 1'b0;
    logic [4:0]      dp_opcode;
    logic [3*DW-1:0] dp_src;
    logic            dp_res_valid = 1'b0;
    logic [DW-1:0]   dp_res_data = '0;
    logic            sram_wr_req;
    logic            sram_wr_gnt = 1'b0;
    logic [AW-1:0]   sram_wr_addr;
    logic [DW-1:0]   sram_wr_data;
    logic            busy;
    logic            done;

    vpu_op_sequencer #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_nsrc(req_nsrc), .req_src_addr(req_src_addr), .req_dst_addr(req_dst_addr),
        .req_len(req_len),
        .sram_rd_req(sram_rd_req), .sram_rd_addr(sram_rd_addr), .sram_rd_gnt(sram_rd_gnt),
        .sram_rd_rvalid(sram_rd_rvalid), .sram_rd_rdata(sram_rd_rdata),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_opcode(dp_opcode), .dp_src(dp_src),
        .dp_res_valid(dp_res_valid), .dp_res_data(dp_res_data),
        .sram_wr_req(sram_wr_req), .sram_wr_gnt(sram_wr_gnt), .sram_wr_addr(sram_wr_addr),
        .sram_wr_data(sram_wr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Knobs written only by the test tasks
    int rd_wait = 0, dp_wait = 0, wr_wait = 0;
    bit spur_res = 1'b0, dp_no_res = 1'b0, force_res = 1'b0;
    int cur_nsrc = 0;

    // Responder state and logs written only by the responder process
    int rd_left = 0, dp_left = 0, wr_left = 0;
    bit rd_pend = 1'b0, res_pend = 1'b0;
    bit rd_hold = 1'b0, dp_hold = 1'b0, wr_hold = 1'b0;
    logic [DW-1:0]   rd_data_pend = '0, res_data_pend = '0;
    logic [AW-1:0]   rd_hold_addr = '0, wr_hold_addr = '0;
    logic [DW-1:0]   wr_hold_data = '0;
    logic [4:0]      dp_hold_op = '0;
    logic [3*DW-1:0] dp_hold_src = '0;
    logic [AW-1:0]   rd_log[$];
    logic [AW-1:0]   wr_addr_log[$];
    logic [DW-1:0]   wr_data_log[$];
    int done_cnt = 0, done_cyc = -1, dpv_rise_cyc = -1, last_wr_cyc = -1;
    int rd_req_cycles = 0, dpv_cycles = 0, wr_req_cycles = 0;
    int stab_err = 0, slot_err = 0, dp_issues = 0;
    bit dpv_prev = 1'b0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {32{a ^ 16'hC3A5}};
    endfunction

    function automatic logic [DW-1:0] combine(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                                              input logic [DW-1:0] s2, input logic [4:0] op);
        return s0 ^ (s1 << 1) ^ (s2 << 2) ^ DW'(op);
    endfunction

    // Expected result for element v, computed from addresses alone
    function automatic logic [DW-1:0] exp_res(input logic [4:0] op, input int n,
                                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                              input logic [AW-1:0] a2, input int v);
        logic [DW-1:0] s1, s2;
        s1 = (n > 1) ? mem_word(a1 + AW'(v)) : '0;
        s2 = (n > 2) ? mem_word(a2 + AW'(v)) : '0;
        return combine(mem_word(a0 + AW'(v)), s1, s2, op);
    endfunction

    // SRAM and datapath responders, driven on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            sram_rd_gnt = 1'b0; sram_rd_rvalid = 1'b0; sram_rd_rdata = '0;
            dp_ready = 1'b0; dp_res_valid = 1'b0; dp_res_data = '0; sram_wr_gnt = 1'b0;
            rd_pend = 1'b0; res_pend = 1'b0; rd_hold = 1'b0; dp_hold = 1'b0; wr_hold = 1'b0;
            dpv_prev = 1'b0;
        end else begin
            sram_rd_rvalid = rd_pend;
            sram_rd_rdata  = rd_pend ? rd_data_pend : '0;
            rd_pend = 1'b0;
            sram_rd_gnt = 1'b0;
            if (sram_rd_req) begin
                rd_req_cycles++;
                if (!rd_hold) begin
                    rd_hold = 1'b1; rd_hold_addr = sram_rd_addr; rd_left = rd_wait;
                end else if (sram_rd_addr !== rd_hold_addr) stab_err++;
                if (rd_left == 0) begin
                    sram_rd_gnt = 1'b1; rd_pend = 1'b1; rd_hold = 1'b0;
                    rd_data_pend = mem_word(sram_rd_addr);
                    rd_log.push_back(sram_rd_addr);
                end else rd_left--;
            end

            dp_res_valid = res_pend || force_res || (spur_res && sram_rd_rvalid);
            dp_res_data  = res_pend ? res_data_pend : {16{32'hDEADBEEF}};
            res_pend = 1'b0;
            dp_ready = 1'b0;
            if (dp_valid && !dpv_prev) dpv_rise_cyc = cyc;
            dpv_prev = dp_valid;
            if (dp_valid) begin
                dpv_cycles++;
                if (cur_nsrc == 1 && dp_src[DW +: 2*DW] !== '0) slot_err++;
                if (!dp_hold) begin
                    dp_hold = 1'b1; dp_hold_op = dp_opcode; dp_hold_src = dp_src; dp_left = dp_wait;
                end else if (dp_opcode !== dp_hold_op || dp_src !== dp_hold_src) stab_err++;
                if (dp_left == 0) begin
                    dp_ready = 1'b1; dp_hold = 1'b0; dp_issues++;
                    res_pend = !dp_no_res;
                    res_data_pend = combine(dp_src[0 +: DW], dp_src[DW +: DW], dp_src[2*DW +: DW],
                                            dp_opcode);
                end else dp_left--;
            end

            sram_wr_gnt = 1'b0;
            if (sram_wr_req) begin
                wr_req_cycles++;
                if (!wr_hold) begin
                    wr_hold = 1'b1; wr_hold_addr = sram_wr_addr; wr_hold_data = sram_wr_data;
                    wr_left = wr_wait;
                end else if (sram_wr_addr !== wr_hold_addr || sram_wr_data !== wr_hold_data)
                    stab_err++;
                if (wr_left == 0) begin
                    sram_wr_gnt = 1'b1; wr_hold = 1'b0; last_wr_cyc = cyc;
                    wr_addr_log.push_back(sram_wr_addr);
                    wr_data_log.push_back(sram_wr_data);
                end else wr_left--;
            end

            if (done) begin
                done_cnt++; done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command; acc is the cycle index right after the accepting edge
    task automatic send_cmd(input logic [4:0] op, input logic [1:0] n, input logic [AW-1:0] a0,
                            input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                            input logic [AW-1:0] dst, input logic [LW-1:0] len, output int acc);
        int guard;
        req_opcode = op; req_nsrc = n; req_src_addr = {a2, a1, a0};
        req_dst_addr = dst; req_len = len; req_valid = 1'b1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int guard;
        guard = 0;
        while (done_cnt == d0 && guard < 2000) begin
            tick();
            guard++;
        end
        tick();
        if (done_cnt == d0) begin
            vec_cnt++; err_cnt++;
            $display("FAIL %s: timeout waiting for done, got %0d pulses, required 1", nm, done_cnt - d0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        vec_cnt++;
        if ({req_ready, busy, done} !== 3'b100) begin
            err_cnt++;
            $display("FAIL reset_status: ready/busy/done=%b required 100", {req_ready, busy, done});
        end
        vec_cnt++;
        if ({sram_rd_req, dp_valid, sram_wr_req} !== 3'b000) begin
            err_cnt++;
            $display("FAIL reset_reqs: rd/dp/wr=%b required 000", {sram_rd_req, dp_valid, sram_wr_req});
        end
        vec_cnt++;
        if (sram_rd_addr !== '0 || sram_wr_addr !== '0 || sram_wr_data !== '0 || dp_src !== '0) begin
            err_cnt++;
            $display("FAIL reset_data: rd_addr=%h wr_addr=%h required 0", sram_rd_addr, sram_wr_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int acc, rb, wb, d0;
        logic [DW-1:0] e;
        rb = rd_log.size(); wb = wr_addr_log.size(); d0 = done_cnt;
        send_cmd(5'h0A, 2'd2, 16'h0010, 16'h0020, 16'h0000, 16'h0030, 8'd1, acc);
        wait_done(d0, "basic");
        vec_cnt++;
        if (rd_log.size() - rb != 2 || rd_log[rb] !== 16'h0010 || rd_log[rb+1] !== 16'h0020) begin
            err_cnt++;
            $display("FAIL basic_reads: %0d reads first=%h, required 2 reads 0010,0020",
                     rd_log.size() - rb, rd_log[rb]);
        end
        vec_cnt++;
        if (dpv_rise_cyc - (acc - 1) != 5) begin
            err_cnt++;
            $display("FAIL basic_dp_latency: dp_valid at T+%0d required T+5", dpv_rise_cyc - (acc - 1));
        end
        vec_cnt++;
        if (wr_addr_log.size() - wb != 1 || wr_addr_log[wb] !== 16'h0030) begin
            err_cnt++;
            $display("FAIL basic_wr_addr: %0d writes addr=%h required 1 at 0030",
                     wr_addr_log.size() - wb, wr_addr_log[wb]);
        end
        e = exp_res(5'h0A, 2, 16'h0010, 16'h0020, 16'h0000, 0);
        vec_cnt++;
        if (wr_data_log[wb] !== e) begin
            err_cnt++;
            $display("FAIL basic_wr_data: got %h required %h", wr_data_log[wb][63:0], e[63:0]);
        end
        vec_cnt++;
        if (done_cyc - (acc - 1) != 8 || done_cnt - d0 != 1) begin
            err_cnt++;
            $display("FAIL basic_done: done at T+%0d (%0d pulses) required T+8 (1)",
                     done_cyc - (acc - 1), done_cnt - d0);
        end
    endtask

    // Four-element, three-source run; stalls optionally applied on every handshake
    task automatic run_wrap(input int w, input string nm);
        int acc, rb, wb, d0, s0, rq0, dv0, wq0;
        logic [AW-1:0] ea;
        logic [DW-1:0] e;
        rd_wait = w; dp_wait = w; wr_wait = w;
        rb = rd_log.size(); wb = wr_addr_log.size(); d0 = done_cnt; s0 = stab_err;
        rq0 = rd_req_cycles; dv0 = dpv_cycles; wq0 = wr_req_cycles;
        send_cmd(5'h03, 2'd3, 16'h0100, 16'h0200, 16'h0300, 16'hFFFE, 8'd4, acc);
        wait_done(d0, nm);
        vec_cnt++;
        if (rd_log.size() - rb != 12) begin
            err_cnt++;
            $display("FAIL %s_read_count: %0d required 12", nm, rd_log.size() - rb);
        end
        for (int v = 0; v < 4 && rd_log.size() - rb == 12; v++) begin
            for (int k = 0; k < 3; k++) begin
                ea = 16'(16'h0100 * (k + 1) + v);
                vec_cnt++;
                if (rd_log[rb + 3*v + k] !== ea) begin
                    err_cnt++;
                    $display("FAIL %s_rd_addr[%0d]: got %h required %h", nm, 3*v + k,
                             rd_log[rb + 3*v + k], ea);
                end
            end
        end
        vec_cnt++;
        if (wr_addr_log.size() - wb != 4) begin
            err_cnt++;
            $display("FAIL %s_write_count: %0d required 4", nm, wr_addr_log.size() - wb);
        end
        for (int v = 0; v < 4 && wr_addr_log.size() - wb == 4; v++) begin
            ea = 16'(32'hFFFE + v);
            e = exp_res(5'h03, 3, 16'h0100, 16'h0200, 16'h0300, v);
            vec_cnt++;
            if (wr_addr_log[wb + v] !== ea || wr_data_log[wb + v] !== e) begin
                err_cnt++;
                $display("FAIL %s_write[%0d]: addr %h data %h required %h %h", nm, v,
                         wr_addr_log[wb + v], wr_data_log[wb + v][63:0], ea, e[63:0]);
            end
        end
        vec_cnt++;
        if (done_cnt - d0 != 1 || done_cyc != last_wr_cyc + 1) begin
            err_cnt++;
            $display("FAIL %s_done: %0d pulses at cycle %0d, required 1 at %0d", nm,
                     done_cnt - d0, done_cyc, last_wr_cyc + 1);
        end
        vec_cnt++;
        if (stab_err != s0) begin
            err_cnt++;
            $display("FAIL %s_stability: %0d unstable cycles required 0", nm, stab_err - s0);
        end
        vec_cnt++;
        if (rd_req_cycles - rq0 != 12*(w+1) || dpv_cycles - dv0 != 4*(w+1) ||
            wr_req_cycles - wq0 != 4*(w+1)) begin
            err_cnt++;
            $display("FAIL %s_hold_cycles: rd %0d dp %0d wr %0d required %0d %0d %0d", nm,
                     rd_req_cycles - rq0, dpv_cycles - dv0, wr_req_cycles - wq0,
                     12*(w+1), 4*(w+1), 4*(w+1));
        end
        rd_wait = 0; dp_wait = 0; wr_wait = 0;
    endtask

    task automatic test_wrap();
        run_wrap(0, "wrap");
    endtask

    task automatic test_stall();
        run_wrap(5, "stall");
    endtask

    task automatic test_len_zero();
        int acc, d0, rq0, dv0, wq0;
        d0 = done_cnt; rq0 = rd_req_cycles; dv0 = dpv_cycles; wq0 = wr_req_cycles;
        send_cmd(5'h01, 2'd2, 16'h0040, 16'h0050, 16'h0060, 16'h0070, 8'd0, acc);
        wait_done(d0, "len0");
        repeat (3) tick();
        vec_cnt++;
        if (done_cnt - d0 != 1 || done_cyc < acc || done_cyc > acc + 1) begin
            err_cnt++;
            $display("FAIL len0_done: %0d pulses at acc+%0d required 1 within 2 cycles",
                     done_cnt - d0, done_cyc - acc);
        end
        vec_cnt++;
        if (rd_req_cycles != rq0 || dpv_cycles != dv0 || wr_req_cycles != wq0) begin
            err_cnt++;
            $display("FAIL len0_traffic: rd %0d dp %0d wr %0d required 0 0 0",
                     rd_req_cycles - rq0, dpv_cycles - dv0, wr_req_cycles - wq0);
        end
    endtask

    task automatic test_nsrc1();
        int acc, rb, wb, d0, se0;
        logic [DW-1:0] e;
        spur_res = 1'b1; cur_nsrc = 1;
        rb = rd_log.size(); wb = wr_addr_log.size(); d0 = done_cnt; se0 = slot_err;
        send_cmd(5'h11, 2'd1, 16'h0040, 16'h1234, 16'h5678, 16'h0050, 8'd2, acc);
        wait_done(d0, "nsrc1");
        vec_cnt++;
        if (slot_err != se0) begin
            err_cnt++;
            $display("FAIL nsrc1_unused_slots: %0d nonzero issues required 0", slot_err - se0);
        end
        vec_cnt++;
        if (rd_log.size() - rb != 2 || rd_log[rb] !== 16'h0040 || rd_log[rb+1] !== 16'h0041) begin
            err_cnt++;
            $display("FAIL nsrc1_reads: %0d reads first %h required 2 at 0040,0041",
                     rd_log.size() - rb, rd_log[rb]);
        end
        for (int v = 0; v < 2 && wr_addr_log.size() - wb == 2; v++) begin
            e = exp_res(5'h11, 1, 16'h0040, 16'h1234, 16'h5678, v);
            vec_cnt++;
            if (wr_data_log[wb + v] !== e || wr_addr_log[wb + v] !== 16'(16'h0050 + v)) begin
                err_cnt++;
                $display("FAIL nsrc1_write[%0d]: addr %h data %h required %h %h", v,
                         wr_addr_log[wb + v], wr_data_log[wb + v][63:0], 16'(16'h0050 + v), e[63:0]);
            end
        end
        vec_cnt++;
        if (wr_addr_log.size() - wb != 2 || done_cnt - d0 != 1) begin
            err_cnt++;
            $display("FAIL nsrc1_count: %0d writes %0d dones required 2 1",
                     wr_addr_log.size() - wb, done_cnt - d0);
        end
        spur_res = 1'b0;
        // Zero operand count behaves as one
        rb = rd_log.size(); wb = wr_addr_log.size(); d0 = done_cnt;
        send_cmd(5'h02, 2'd0, 16'h0800, 16'h0900, 16'h0A00, 16'h0B00, 8'd1, acc);
        wait_done(d0, "nsrc0");
        e = exp_res(5'h02, 1, 16'h0800, 16'h0900, 16'h0A00, 0);
        vec_cnt++;
        if (rd_log.size() - rb != 1 || wr_addr_log.size() - wb != 1 || wr_data_log[wb] !== e) begin
            err_cnt++;
            $display("FAIL nsrc0_as_one: %0d reads %0d writes required 1 1 with matching data",
                     rd_log.size() - rb, wr_addr_log.size() - wb);
        end
        cur_nsrc = 0;
    endtask

    task automatic test_reset_mid();
        int acc, d0, di0, guard, wb;
        logic [DW-1:0] e;
        dp_no_res = 1'b1;
        d0 = done_cnt; di0 = dp_issues;
        send_cmd(5'h07, 2'd2, 16'h0300, 16'h0400, 16'h0000, 16'h0500, 8'd1, acc);
        guard = 0;
        while (dp_issues == di0 && guard < 100) begin
            tick();
            guard++;
        end
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({req_ready, busy, done} !== 3'b100) begin
            err_cnt++;
            $display("FAIL midreset_status: ready/busy/done=%b required 100", {req_ready, busy, done});
        end
        dp_no_res = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        force_res = 1'b1;
        tick();
        force_res = 1'b0;
        repeat (3) tick();
        vec_cnt++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL midreset_abort: %0d dones busy=%b required 0 0", done_cnt - d0, busy);
        end
        wb = wr_addr_log.size(); d0 = done_cnt;
        send_cmd(5'h07, 2'd2, 16'h0300, 16'h0400, 16'h0000, 16'h0500, 8'd1, acc);
        wait_done(d0, "after_reset");
        e = exp_res(5'h07, 2, 16'h0300, 16'h0400, 16'h0000, 0);
        vec_cnt++;
        if (wr_addr_log.size() - wb != 1 || wr_addr_log[wb] !== 16'h0500 || wr_data_log[wb] !== e) begin
            err_cnt++;
            $display("FAIL after_reset_write: %0d writes addr %h required 1 at 0500 with matching data",
                     wr_addr_log.size() - wb, wr_addr_log[wb]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_len_zero();
        test_stall();
        test_nsrc1();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
